// File: rtl/ddr_deser_pkg.sv
// Shared types and constants for the DDR deserializer/aligner (ddr_deser_align and ddr_sync_match).
package ddr_deser_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int               W_DEF    = 10;
  localparam logic [W_DEF-1:0] SYNC_DEF = 10'b0011111010;
  localparam int               HALF     = W_DEF / 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ddr_sync_match.sv
// Compares both bit-phase windows of the DDR history against the alignment word.
module ddr_sync_match #(
  parameter int W = 10
) (
  input  logic [W:0]   h_i,
  input  logic [W-1:0] sync_i,
  output logic         match_a_o,
  output logic         match_b_o
);

  assign match_a_o = (h_i[W-1:0] == sync_i);
  assign match_b_o = (h_i[W:1]   == sync_i);

endmodule

// File: rtl/ddr_deser_align.sv
// Rebuilds W-bit words from a 2-bit-per-clock DDR stream, locking on SYNC at either bit phase.
// Optional macro DDR_DESER_LOSS_DET_EN: drop lock after LOSS_WORDS consecutive non-SYNC words.
module ddr_deser_align
  import ddr_deser_pkg::*;
#(
  parameter int          W          = W_DEF,
  parameter logic [W-1:0] SYNC      = SYNC_DEF,
  parameter int          LOSS_WORDS = 64
) (
  input  logic         c,
  input  logic         rst_n,
  input  logic [1:0]   d,
  input  logic         realign,
  output logic [W-1:0] o,
  output logic         ov,
  output logic         locked,
  output logic         sync_det
);

  localparam int HW = W / 2;
  localparam int CW = cnt_width(HW);

  if ((W % 2) != 0 || W < 4 || W > 32 || LOSS_WORDS < 1) begin : g_param_check
    $error("ddr_deser_align: W must be even in 4..32 and LOSS_WORDS >= 1");
  end

  state_t         state_q, state_d;
  logic [W:0]     h_q, h_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           phase_q, phase_d;
  logic [W-1:0]   o_q, o_d;
  logic           ov_q, ov_d;
  logic           locked_q, locked_d;
  logic           sync_det_q, sync_det_d;
  logic           match_a, match_b;
  logic [W-1:0]   word;
  logic           word_end;

`ifdef DDR_DESER_LOSS_DET_EN
  localparam int MW = cnt_width(LOSS_WORDS);
  logic [MW-1:0]  miss_q, miss_d;
`endif

  ddr_sync_match #(.W(W)) u_match (
    .h_i       (h_q),
    .sync_i    (SYNC),
    .match_a_o (match_a),
    .match_b_o (match_b)
  );

  assign word     = phase_q ? h_q[W:1] : h_q[W-1:0];
  assign word_end = (cnt_q == CW'(HW - 1));

  always_comb begin
    h_d        = {h_q[W-2:0], d[0], d[1]};
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    o_d        = o_q;
    ov_d       = 1'b0;
    sync_det_d = 1'b0;
`ifdef DDR_DESER_LOSS_DET_EN
    miss_d     = miss_q;
`endif
    if (realign) begin
      state_d = SEARCH;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SEARCH: begin
          // Window A takes precedence when both phases see SYNC.
          if (match_a || match_b) begin
            state_d = LOCKED;
            cnt_d   = '0;
            phase_d = ~match_a;
`ifdef DDR_DESER_LOSS_DET_EN
            miss_d  = '0;
`endif
          end
        end
        LOCKED: begin
          cnt_d = word_end ? '0 : cnt_q + 1'b1;
          if (word_end) begin
            o_d        = word;
            ov_d       = 1'b1;
            sync_det_d = (word == SYNC);
`ifdef DDR_DESER_LOSS_DET_EN
            if (word == SYNC) begin
              miss_d = '0;
            end else if (miss_q == MW'(LOSS_WORDS - 1)) begin
              state_d = SEARCH;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
`endif
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge c) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      h_q        <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      o_q        <= '0;
      ov_q       <= 1'b0;
      locked_q   <= 1'b0;
      sync_det_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      o_q        <= o_d;
      ov_q       <= ov_d;
      locked_q   <= locked_d;
      sync_det_q <= sync_det_d;
    end
  end

`ifdef DDR_DESER_LOSS_DET_EN
  always_ff @(posedge c) begin
    if (!rst_n) miss_q <= '0;
    else        miss_q <= miss_d;
  end
`endif

  assign o        = o_q;
  assign ov       = ov_q;
  assign locked   = locked_q;
  assign sync_det = sync_det_q;

endmodule

// File: tb/tb_ddr_deser_align.sv
// Self-checking bench for ddr_deser_align (W=10, SYNC=0FA, LOSS_WORDS=4) against a bit-stream reference model.
module tb_ddr_deser_align;

  localparam int             W    = 10;
  localparam logic [W-1:0]   SYNC = 10'h0FA;
  localparam int             HW   = W / 2;
  localparam int             LOSS = 4;

  logic         c = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   d = 2'b00;
  logic         realign = 1'b0;
  logic [W-1:0] o;
  logic         ov, locked, sync_det;

  int total = 0;
  int bad   = 0;

  always #5 c = ~c;

  ddr_deser_align #(.W(W), .SYNC(SYNC), .LOSS_WORDS(LOSS)) dut (
    .c(c), .rst_n(rst_n), .d(d), .realign(realign),
    .o(o), .ov(ov), .locked(locked), .sync_det(sync_det)
  );

  // Stimulus bit stream (time order) and the reference model's view of received bits.
  bit stim_q[$];
  bit hist[$];
  bit m_locked, m_phase;
  int m_since, m_miss;
  logic [W-1:0] e_o;
  bit e_ov, e_locked, e_sd;

  // Last W received bits, excluding the newest 'skip' bits; bits before reset read as 0.
  function automatic logic [W-1:0] window(input int skip);
    logic [W-1:0] w;
    int sz;
    sz = hist.size();
    for (int i = 0; i < W; i++) begin
      int idx;
      idx = sz - skip - W + i;
      w[W-1-i] = (idx >= 0) ? hist[idx] : 1'b0;
    end
    return w;
  endfunction

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) stim_q.push_back(w[i]);
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(1'b0);
  endtask

  function automatic logic [W-1:0] rand_nonsync();
    logic [W-1:0] w;
    do w = W'($urandom); while (w == SYNC);
    return w;
  endfunction

  // One clock: drive on the falling edge, then advance the reference model at the rising edge.
  task automatic step(input bit rn, input bit ra);
    bit b0, b1;
    logic [W-1:0] wa, wb;
    @(negedge c);
    b0 = (stim_q.size() > 0) ? stim_q.pop_front() : 1'b0;
    b1 = (stim_q.size() > 0) ? stim_q.pop_front() : 1'b0;
    rst_n   = rn;
    realign = ra;
    d       = {b1, b0};
    @(posedge c);
    if (!rn) begin
      hist.delete();
      m_locked = 0; m_phase = 0; m_since = 0; m_miss = 0;
      e_o = '0; e_ov = 0; e_sd = 0;
    end else begin
      wa = window(0);
      wb = window(1);
      e_ov = 0;
      e_sd = 0;
      if (ra) begin
        m_locked = 0;
      end else if (!m_locked) begin
        if (wa == SYNC) begin
          m_locked = 1; m_phase = 0; m_since = 0; m_miss = 0;
        end else if (wb == SYNC) begin
          m_locked = 1; m_phase = 1; m_since = 0; m_miss = 0;
        end
      end else begin
        m_since++;
        if (m_since % HW == 0) begin
          e_o  = m_phase ? wb : wa;
          e_ov = 1;
          e_sd = (e_o == SYNC);
`ifdef DDR_DESER_LOSS_DET_EN
          if (e_sd) m_miss = 0;
          else if (m_miss == LOSS - 1) m_locked = 0;
          else m_miss++;
`endif
        end
      end
      hist.push_back(b0);
      hist.push_back(b1);
      while (hist.size() > 4 * W) void'(hist.pop_front());
    end
    e_locked = m_locked;
  endtask

  task automatic test_reset();
    stim_q.delete();
    step(0, 0);
    step(0, 0);
    #1;
    total++;
    if (o !== '0 || ov !== 1'b0 || locked !== 1'b0 || sync_det !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got o=%h ov=%b lk=%b sd=%b, want all 0", o, ov, locked, sync_det);
    end
  endtask

  // Lock on zeros+SYNC+3FF+155 at the given bit offset; checks lock edge, word order and spacing.
  task automatic test_lock(input int offset, input int lock_exp, input string nm);
    int k, lock_at, nov;
    int ovc[2];
    logic [W-1:0] wds[2];
    step(0, 0);
    stim_q.delete();
    push_zeros(20 + offset);
    push_word(SYNC);
    push_word(10'h3FF);
    push_word(10'h155);
    lock_at = -1; nov = 0;
    for (k = 1; k <= 32; k++) begin
      step(1, 0);
      #1;
      total++;
      if ({o, ov, locked, sync_det} !== {e_o, e_ov, e_locked, e_sd}) begin
        bad++;
        $display("FAIL %s_cyc%0d: got o=%h ov=%b lk=%b sd=%b want o=%h ov=%b lk=%b sd=%b",
                 nm, k, o, ov, locked, sync_det, e_o, e_ov, e_locked, e_sd);
      end
      if (locked === 1'b1 && lock_at < 0) lock_at = k;
      if (ov === 1'b1 && nov < 2) begin ovc[nov] = k; wds[nov] = o; nov++; end
    end
    total++;
    if (lock_at != lock_exp) begin
      bad++; $display("FAIL %s_lock_edge: got %0d want %0d", nm, lock_at, lock_exp);
    end
    total++;
    if (nov != 2) begin
      bad++; $display("FAIL %s_ov_count: got %0d want 2", nm, nov);
    end else begin
      total++;
      if (wds[0] !== 10'h3FF || wds[1] !== 10'h155) begin
        bad++; $display("FAIL %s_words: got %h %h want 3ff 155", nm, wds[0], wds[1]);
      end
      total++;
      if (ovc[0] - lock_at != HW || ovc[1] - ovc[0] != HW) begin
        bad++; $display("FAIL %s_spacing: got %0d %0d want %0d %0d", nm, ovc[0] - lock_at, ovc[1] - ovc[0], HW, HW);
      end
    end
  endtask

  task automatic test_sync_every4();
    int nov, nsd, last, badsd, badgap;
    step(0, 0);
    stim_q.delete();
    push_zeros(20);
    push_word(SYNC);
    for (int i = 0; i < 12; i++) push_word((i % 4 == 3) ? SYNC : rand_nonsync());
    nov = 0; nsd = 0; last = -1; badsd = 0; badgap = 0;
    for (int k = 1; k <= 78; k++) begin
      step(1, 0);
      #1;
      total++;
      if ({o, ov, locked, sync_det} !== {e_o, e_ov, e_locked, e_sd}) begin
        bad++;
        $display("FAIL every4_cyc%0d: got o=%h ov=%b lk=%b sd=%b want o=%h ov=%b lk=%b sd=%b",
                 k, o, ov, locked, sync_det, e_o, e_ov, e_locked, e_sd);
      end
      if (ov === 1'b1 && nov < 12) begin
        if (sync_det !== ((nov % 4 == 3) ? 1'b1 : 1'b0)) badsd++;
        if (sync_det === 1'b1) nsd++;
        if (last >= 0 && k - last != HW) badgap++;
        last = k;
        nov++;
      end
    end
    total++;
    if (nov != 12 || nsd != 3 || badsd != 0 || badgap != 0) begin
      bad++;
      $display("FAIL every4_summary: got ov=%0d sd=%0d sd_err=%0d gap_err=%0d want 12 3 0 0", nov, nsd, badsd, badgap);
    end
  endtask

  task automatic test_realign();
    int nov;
    logic [W-1:0] lastw;
    step(0, 0);
    stim_q.delete();
    push_zeros(20);
    push_word(SYNC);
    for (int i = 0; i < 4; i++) push_word(rand_nonsync());
    repeat (28) step(1, 0);
    stim_q.delete();
    for (int i = 0; i < 2; i++) begin push_word(10'h3FF); push_word(10'h000); end
    step(1, 1);
    #1;
    total++;
    if (locked !== 1'b0 || ov !== 1'b0) begin
      bad++; $display("FAIL realign_drop: got lk=%b ov=%b want 0 0", locked, ov);
    end
    nov = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1, 0);
      #1;
      total++;
      if ({o, ov, locked, sync_det} !== {e_o, e_ov, e_locked, e_sd}) begin
        bad++;
        $display("FAIL realign_cyc%0d: got o=%h ov=%b lk=%b sd=%b want o=%h ov=%b lk=%b sd=%b",
                 k, o, ov, locked, sync_det, e_o, e_ov, e_locked, e_sd);
      end
      if (ov === 1'b1) nov++;
    end
    total++;
    if (nov != 0) begin
      bad++; $display("FAIL realign_no_ov: got %0d strobes want 0", nov);
    end
    push_word(SYNC);
    push_word(10'h3FF);
    lastw = '0;
    repeat (14) begin
      step(1, 0);
      #1;
      if (ov === 1'b1) lastw = o;
    end
    total++;
    if (locked !== 1'b1 || lastw !== 10'h3FF) begin
      bad++; $display("FAIL realign_relock: got lk=%b word=%h want 1 3ff", locked, lastw);
    end
  endtask

  task automatic test_reset_midword();
    int nov;
    step(0, 0);
    stim_q.delete();
    push_zeros(20);
    push_word(SYNC);
    push_word(10'h3FF);
    repeat (18) step(1, 0);
    stim_q.delete();
    step(0, 0);
    #1;
    total++;
    if (o !== '0 || ov !== 1'b0 || locked !== 1'b0 || sync_det !== 1'b0) begin
      bad++; $display("FAIL midreset_state: got o=%h ov=%b lk=%b sd=%b want all 0", o, ov, locked, sync_det);
    end
    nov = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1, 0);
      #1;
      total++;
      if ({o, ov, locked, sync_det} !== {e_o, e_ov, e_locked, e_sd}) begin
        bad++;
        $display("FAIL midreset_cyc%0d: got o=%h ov=%b lk=%b sd=%b want o=%h ov=%b lk=%b sd=%b",
                 k, o, ov, locked, sync_det, e_o, e_ov, e_locked, e_sd);
      end
      if (ov === 1'b1) nov++;
    end
    total++;
    if (nov != 0 || locked !== 1'b0) begin
      bad++; $display("FAIL midreset_partial: got ov=%0d lk=%b want 0 0", nov, locked);
    end
  endtask

  task automatic test_loss();
    int nov;
    bit lk_at[8];
    step(0, 0);
    stim_q.delete();
    push_zeros(20);
    push_word(SYNC);
    for (int i = 0; i < 8; i++) push_word(rand_nonsync());
    nov = 0;
    for (int k = 1; k <= 56; k++) begin
      step(1, 0);
      #1;
      total++;
      if ({o, ov, locked, sync_det} !== {e_o, e_ov, e_locked, e_sd}) begin
        bad++;
        $display("FAIL loss_cyc%0d: got o=%h ov=%b lk=%b sd=%b want o=%h ov=%b lk=%b sd=%b",
                 k, o, ov, locked, sync_det, e_o, e_ov, e_locked, e_sd);
      end
      if (ov === 1'b1 && nov < 8) begin lk_at[nov] = locked; nov++; end
    end
`ifdef DDR_DESER_LOSS_DET_EN
    total++;
    if (nov < 4 || lk_at[2] !== 1'b1 || lk_at[3] !== 1'b0) begin
      bad++; $display("FAIL loss_drop: got ov=%0d lk3=%b lk4=%b want >=4 1 0", nov, lk_at[2], lk_at[3]);
    end
`else
    total++;
    if (nov != 8 || locked !== 1'b1 || lk_at[7] !== 1'b1) begin
      bad++; $display("FAIL loss_hold: got ov=%0d lk=%b want 8 1", nov, locked);
    end
`endif
  endtask

  task automatic test_random_soak();
    step(0, 0);
    stim_q.delete();
    for (int k = 1; k <= 400; k++) begin
      if (stim_q.size() < 4) begin
        if ($urandom_range(3) == 0) push_word(SYNC);
        else push_word(W'($urandom));
        if ($urandom_range(5) == 0) stim_q.push_back(1'($urandom));
      end
      step(1, ($urandom_range(40) == 0));
      #1;
      total++;
      if ({o, ov, locked, sync_det} !== {e_o, e_ov, e_locked, e_sd}) begin
        bad++;
        $display("FAIL soak_cyc%0d: got o=%h ov=%b lk=%b sd=%b want o=%h ov=%b lk=%b sd=%b",
                 k, o, ov, locked, sync_det, e_o, e_ov, e_locked, e_sd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock(0, 16, "phase0");
    test_lock(1, 17, "phase1");
    test_sync_every4();
    test_realign();
    test_reset_midword();
    test_loss();
    test_random_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
